mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the physical memory controller.
- Shares the controller's single is_write/addr/data/busy port between the instruction-fetch requester (i_*) and the data-memory requester (d_*).
- Sequences write issue and busy-wait, registers read data, and returns a one-cycle ack to the granted requester.
- Fixed data-over-instruction priority; includes a watchdog on stuck busy.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between instruction-fetch and data requesters.
// Define MEM_ARB_FAIR_EN to bound consecutive data grants while an instruction fetch is waiting.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FAIR_LIMIT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_is_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy,
  output logic        timeout_err
);

  // state    | meaning
  // IDLE     | no transaction; grant decision made here
  // RD       | read presented to controller, waiting for busy low
  // WR_ISSUE | one-cycle write strobe to controller
  // WR_WAIT  | write accepted, waiting for busy low
  // DONE     | owner ack cycle; no grant
  typedef enum logic [2:0] {IDLE, RD, WR_ISSUE, WR_WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255 || FAIR_LIMIT == 0 || FAIR_LIMIT > 7)
  begin : g_param_check
    $error("mem_arbiter: TIMEOUT_CYCLES or FAIR_LIMIT out of range");
  end

  state_t      state, state_nxt;
  logic        owner_d;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [7:0]  wd_cnt;
  logic [7:0]  wd_inc;
  logic        wd_hit;
  logic        waiting;
  logic        grant;
  logic        grant_d;

  assign grant   = i_req | d_req;
  assign waiting = (state == RD) || (state == WR_WAIT);
  assign wd_inc  = wd_cnt + 8'd1;
  // Abort only while the controller still reports busy on the final allowed cycle.
  assign wd_hit  = mem_busy && (wd_inc == TIMEOUT_VAL);

`ifdef MEM_ARB_FAIR_EN
  logic [2:0] fair_cnt;
  logic       fair_force_i;

  assign fair_force_i = i_req && d_req && (32'(fair_cnt) >= FAIR_LIMIT);
  assign grant_d      = d_req && !fair_force_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_cnt <= '0;
    end else if (state == IDLE && grant) begin
      if (grant_d && i_req) fair_cnt <= fair_cnt + 3'd1;
      else                  fair_cnt <= '0;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant) state_nxt = (grant_d && d_we) ? WR_ISSUE : RD;
      RD:       if (!mem_busy || wd_hit) state_nxt = DONE;
      WR_ISSUE: state_nxt = WR_WAIT;
      WR_WAIT:  if (!mem_busy || wd_hit) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      wd_cnt      <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant) begin
        owner_d   <= grant_d;
        lat_addr  <= grant_d ? d_addr : i_addr;
        lat_wdata <= grant_d ? d_wdata : '0;
      end
      if (waiting) wd_cnt <= wd_inc;
      else         wd_cnt <= '0;
      if (state == RD && (!mem_busy || wd_hit)) begin
        if (owner_d) d_rdata <= mem_busy ? '0 : mem_data_out;
        else         i_rdata <= mem_busy ? '0 : mem_data_out;
      end
      if (waiting && wd_hit) timeout_err <= 1'b1;
    end
  end

  assign i_ack        = (state == DONE) && !owner_d;
  assign d_ack        = (state == DONE) && owner_d;
  assign mem_is_write = (state == WR_ISSUE);
  assign mem_addr     = lat_addr;
  assign mem_data_in  = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int TIMEOUT    = 8;
  localparam int FAIR_LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req, d_req, d_we, mem_busy;
  logic [31:0] i_addr, d_addr, d_wdata, mem_data_out;
  logic        i_ack, d_ack, mem_is_write, timeout_err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_data_in;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_i_rdata, m_d_rdata;
  logic        m_terr;
  int          m_fair;

  mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_is_write(mem_is_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // One complete transaction; the controller holds busy for k cycles of waiting.
  task automatic run_txn(input logic ireq, input logic dreq, input logic we,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [31:0] wdata, input logic [31:0] rdval,
                         input int k, input bit keep, output bit got_d);
    bit          own_d, is_wr, tmo;
    int          ack_n;
    logic [31:0] exp_addr;
    logic [1:0]  exp_ack;
    own_d    = dreq && !(FAIR_EN && ireq && m_fair >= FAIR_LIMIT);
    m_fair   = (own_d && ireq) ? m_fair + 1 : 0;
    is_wr    = own_d && we;
    tmo      = (k >= TIMEOUT);
    exp_addr = own_d ? daddr : iaddr;
    if (is_wr) ack_n = tmo ? TIMEOUT + 2 : k + 3;
    else       ack_n = tmo ? TIMEOUT + 1 : k + 2;
    got_d = 1'b0;
    i_req = ireq; d_req = dreq; d_we = we;
    i_addr = iaddr; d_addr = daddr; d_wdata = wdata;
    mem_data_out = rdval; mem_busy = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= ack_n; n++) begin
      @(negedge clk);
      exp_ack = (n == ack_n) ? (own_d ? 2'b01 : 2'b10) : 2'b00;
      if (n == ack_n) begin
        got_d = d_ack;
        if (!is_wr && own_d)  m_d_rdata = tmo ? 32'h0 : rdval;
        if (!is_wr && !own_d) m_i_rdata = tmo ? 32'h0 : rdval;
        if (tmo) m_terr = 1'b1;
      end
      checks++;
      if ({i_ack, d_ack} !== exp_ack) begin
        errors++;
        $display("FAIL ack cyc=%0d got={i,d}=%b exp=%b", n, {i_ack, d_ack}, exp_ack);
      end
      checks++;
      if (mem_is_write !== (is_wr && n == 1)) begin
        errors++;
        $display("FAIL is_write cyc=%0d got=%b exp=%b", n, mem_is_write, is_wr && n == 1);
      end
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL mem_addr cyc=%0d got=%h exp=%h", n, mem_addr, exp_addr);
      end
      if (is_wr) begin
        checks++;
        if (mem_data_in !== wdata) begin
          errors++;
          $display("FAIL mem_data_in cyc=%0d got=%h exp=%h", n, mem_data_in, wdata);
        end
      end
      checks++;
      if (i_rdata !== m_i_rdata || d_rdata !== m_d_rdata) begin
        errors++;
        $display("FAIL rdata cyc=%0d got i=%h d=%h exp i=%h d=%h",
                 n, i_rdata, d_rdata, m_i_rdata, m_d_rdata);
      end
      checks++;
      if (timeout_err !== m_terr) begin
        errors++;
        $display("FAIL timeout_err cyc=%0d got=%b exp=%b", n, timeout_err, m_terr);
      end
      mem_busy = is_wr ? (n <= k + 1) : (n <= k);
      if (n == 1) begin
        if (own_d) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        end else begin
          i_addr = $urandom;
        end
      end
      if (n == ack_n && !keep) begin
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({i_ack, d_ack} !== 2'b00) begin
      errors++;
      $display("FAIL dup_ack got={i,d}=%b exp=00", {i_ack, d_ack});
    end
  endtask

  task automatic test_reset;
    i_req = 0; d_req = 0; d_we = 0; mem_busy = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_data_out = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({i_ack, d_ack, mem_is_write, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {i_ack, d_ack, mem_is_write, timeout_err});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_data_in !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h din=%h ir=%h dr=%h exp all 0",
               mem_addr, mem_data_in, i_rdata, d_rdata);
    end
    rst = 1'b0;
    m_i_rdata = 0; m_d_rdata = 0; m_terr = 0; m_fair = 0;
    @(negedge clk);
  endtask

  task automatic test_instr_read;
    bit gd;
    run_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h12345678, 0, 0, gd);
    checks++;
    if (i_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL instr_rdata got=%h exp=12345678", i_rdata);
    end
  endtask

  task automatic test_data_write;
    bit gd;
    run_txn(0, 1, 1, 32'h0, 32'h200, 32'hCAFEBABE, 32'h0, 6, 0, gd);
    checks++;
    if (gd !== 1'b1) begin
      errors++;
      $display("FAIL write_owner got d=%b exp=1", gd);
    end
  endtask

  task automatic test_contention;
    bit gd;
    bit seen_i;
    int nd;
    int exp_nd;
    nd = 0; seen_i = 0;
    exp_nd = FAIR_EN ? FAIR_LIMIT : 6;
    for (int j = 0; j < 6 && !seen_i; j++) begin
      run_txn(1, 1, 1'($urandom_range(0, 1)), 32'h500, 32'h600 + 32'(j), $urandom, $urandom,
              $urandom_range(0, 3), 0, gd);
      if (gd) nd++;
      else    seen_i = 1;
    end
    if (!seen_i) begin
      run_txn(1, 0, 0, 32'h500, 32'h0, 32'h0, $urandom, 1, 0, gd);
      checks++;
      if (gd !== 1'b0) begin
        errors++;
        $display("FAIL contention_i_after got d=%b exp=0", gd);
      end
    end
    i_req = 0; d_req = 0;
    checks++;
    if (nd !== exp_nd) begin
      errors++;
      $display("FAIL contention_count got=%0d data acks exp=%0d", nd, exp_nd);
    end
  endtask

  task automatic test_back_to_back;
    bit gd;
    run_txn(1, 0, 0, 32'h300, 32'h0, 32'h0, 32'hA5A5_0001, 1, 1, gd);
    run_txn(1, 0, 0, 32'h304, 32'h0, 32'h0, 32'hA5A5_0002, 0, 0, gd);
    run_txn(0, 1, 1, 32'h0, 32'h700, 32'h1111_2222, 32'h0, 2, 1, gd);
    run_txn(0, 1, 0, 32'h0, 32'h704, 32'h0, 32'h3333_4444, 0, 0, gd);
    i_req = 0; d_req = 0;
  endtask

  task automatic test_random;
    bit gd;
    int sel;
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        i_req = 0; d_req = 0;
        repeat (2) begin
          @(negedge clk);
          checks++;
          if ({i_ack, d_ack, mem_is_write} !== 3'b000) begin
            errors++;
            $display("FAIL idle_quiet got={i,d,wr}=%b exp=000", {i_ack, d_ack, mem_is_write});
          end
        end
      end else begin
        run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, TIMEOUT - 1), 0, gd);
      end
      i_req = 0; d_req = 0;
    end
  endtask

  task automatic test_wd_boundary;
    bit gd;
    run_txn(1, 0, 0, 32'h800, 32'h0, 32'h0, 32'h0BAD_F00D, TIMEOUT - 1, 0, gd);
    run_txn(0, 1, 1, 32'h0, 32'h804, 32'h5555_AAAA, 32'h0, TIMEOUT - 1, 0, gd);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_boundary got timeout_err=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_watchdog;
    bit gd;
    run_txn(1, 0, 0, 32'h400, 32'h0, 32'h0, 32'hDEADBEEF, 20, 0, gd);
    checks++;
    if (i_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wd_rdata got=%h exp=00000000", i_rdata);
    end
    run_txn(0, 1, 0, 32'h0, 32'h404, 32'h0, 32'h7777_8888, 1, 0, gd);
    run_txn(0, 1, 1, 32'h0, 32'h408, 32'h9999_0000, 32'h0, 20, 0, gd);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky got=%b exp=1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_rd;
    i_req = 1; d_req = 0; i_addr = 32'h900; mem_busy = 1; mem_data_out = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h900) begin
      errors++;
      $display("FAIL midrd_addr got=%h exp=00000900", mem_addr);
    end
    rst = 1'b1;
    #1;
    i_req = 0;
    checks++;
    if ({i_ack, d_ack, mem_is_write, timeout_err} !== 4'b0000 ||
        mem_addr !== 32'h0 || mem_data_in !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrd_reset got flags=%b addr=%h din=%h ir=%h dr=%h exp all 0",
               {i_ack, d_ack, mem_is_write, timeout_err}, mem_addr, mem_data_in, i_rdata, d_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_busy = 0;
    m_i_rdata = 0; m_d_rdata = 0; m_terr = 0; m_fair = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({i_ack, d_ack, mem_is_write, timeout_err} !== 4'b0000 || mem_addr !== 32'h0) begin
        errors++;
        $display("FAIL midrd_after got flags=%b addr=%h exp 0", {i_ack, d_ack, mem_is_write, timeout_err},
                 mem_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_data_write();
    test_contention();
    test_back_to_back();
    test_random();
    test_wd_boundary();
    test_watchdog();
    test_reset_mid_rd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
